// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard scoreboard for an in-order pipeline. It keeps one
// pending-latency counter per architectural register. The counter says how
// many more cycles the register's most recent producer needs before its
// result can be forwarded. A decode instruction that reads a register with a
// nonzero counter is held (stall). The block also picks the forwarding source
// for each EX-stage operand, using the priority EX > MEM > WB.
//
// Register 0 is hardwired zero. It is never tracked, never stalls and never
// forwards.
//
// Optional feature (compile-time macro):
//   HAZARD_PERF_EN  When defined, stall_cycles counts the cycles with
//                   stall=1 and flush=0, and saturates at all-ones. When
//                   undefined, stall_cycles is tied to zero and no counter
//                   flops exist.
//
// Parameters:
//   NREGS  number of architectural registers (2**AW)
//   AW     register address width
//   CW     latency counter width (latencies 0 .. 2**CW-1)
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   id_rs1/id_rs2  decode source addresses
//   id_use1/2      decode instruction really reads rs1/rs2
//   id_issue       decode instruction leaves decode this cycle
//   id_rd/id_we    destination of the issuing instruction, and its write enable
//   id_lat         cycles until the issuing result becomes forwardable
//   ex_rs1/ex_rs2  EX-stage source addresses
//   ex/mem/wb_we   stage holds a valid register write
//   ex/mem/wb_rd   stage destination addresses
//   flush          squash all younger in-flight instructions
//   stall          hold decode and insert a bubble (combinational)
//   fwd1/2_sel     EX operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_cycles   stall statistics counter
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          id_issue,
  input  logic [AW-1:0] id_rd,
  input  logic          id_we,
  input  logic [CW-1:0] id_lat,
  input  logic [AW-1:0] ex_rs1,
  input  logic [AW-1:0] ex_rs2,
  input  logic          ex_we,
  input  logic          mem_we,
  input  logic          wb_we,
  input  logic [AW-1:0] ex_rd,
  input  logic [AW-1:0] mem_rd,
  input  logic [AW-1:0] wb_rd,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd1_sel,
  output logic [1:0]    fwd2_sel,
  output logic [31:0]   stall_cycles
);

  // The address space must cover exactly the architectural registers.
  if ((2 ** AW) != NREGS) begin : g_param_chk
    $error("hazard_scoreboard: 2**AW must equal NREGS");
  end

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // Pending counters exist only for registers 1..NREGS-1.
  logic [NREGS-1:1][CW-1:0] pend_r;

  // Lookup view with a constant-zero slot for register 0. Any source address
  // can index it without a special case.
  logic [NREGS-1:0][CW-1:0] cnt_view_s;
  logic                     dep1_s;
  logic                     dep2_s;
  logic                     stall_s;
  logic                     load_s;

  assign cnt_view_s = {pend_r, {CW{1'b0}}};

  // A source only creates a hazard when the instruction really reads it.
  assign dep1_s  = id_use1 && (cnt_view_s[id_rs1] != {CW{1'b0}});
  assign dep2_s  = id_use2 && (cnt_view_s[id_rs2] != {CW{1'b0}});
  assign stall_s = dep1_s || dep2_s;
  assign stall   = stall_s;

  // A stalled instruction does not leave decode. Its issue strobe must not
  // arm a counter even if the pipeline control still drives it.
  assign load_s = id_issue && id_we && (id_rd != {AW{1'b0}}) && !stall_s;

  // Forwarding source select. The youngest matching producer wins.
  // Address 0 never forwards because x0 always reads zero.
  function automatic logic [1:0] fwd_pick(
    input logic [AW-1:0] rs,
    input logic          e_we,
    input logic [AW-1:0] e_rd,
    input logic          m_we,
    input logic [AW-1:0] m_rd,
    input logic          w_we,
    input logic [AW-1:0] w_rd
  );
    logic [1:0] sel;
    if (rs == {AW{1'b0}}) begin
      sel = SEL_RF;
    end else if (e_we && (rs == e_rd)) begin
      sel = SEL_EX;
    end else if (m_we && (rs == m_rd)) begin
      sel = SEL_MEM;
    end else if (w_we && (rs == w_rd)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  assign fwd1_sel = fwd_pick(ex_rs1, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);
  assign fwd2_sel = fwd_pick(ex_rs2, ex_we, ex_rd, mem_we, mem_rd, wb_we, wb_rd);

  // Pending counter update. Priority: reset > flush > issue load > decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (flush) begin
          pend_r[i] <= {CW{1'b0}};
        end else if (load_s && (id_rd == AW'(i))) begin
          pend_r[i] <= id_lat;
        end else if (pend_r[i] != {CW{1'b0}}) begin
          pend_r[i] <= pend_r[i] - CW'(1);
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;

  // Count cycles lost to stalls. Flushed cycles are not counted. Saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (stall_s && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed self-checking bench for hazard_scoreboard. Each cycle, after the
// rising edge, the stimulus is driven. At the same time the expected stall
// and fwd selects are pushed to a queue. A monitor on the falling edge pops
// each entry and compares it with the DUT outputs. The expected stall_cycles
// value is the running count of cycles with stall=1 and flush=0 since the
// last reset. It is zero when HAZARD_PERF_EN is undefined.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use1, id_use2, id_issue, id_we;
  logic [2:0]  id_lat;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_we, mem_we, wb_we, flush;
  logic        stall;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        st;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] sc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    acc_sc = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_issue(id_issue), .id_rd(id_rd), .id_we(id_we), .id_lat(id_lat),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .flush(flush), .stall(stall), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the DUT outputs with the oldest expectation, away from the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".stall"}, {31'd0, stall}, {31'd0, e.st});
      check_val({t, ".fwd1"}, {30'd0, fwd1_sel}, {30'd0, e.f1});
      check_val({t, ".fwd2"}, {30'd0, fwd2_sel}, {30'd0, e.f2});
      check_val({t, ".scyc"}, stall_cycles, e.sc);
    end
  end

  // Push the expected outputs for the inputs just driven.
  task automatic expect_out(input string tag, input logic st,
                            input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    e.st = st;
    e.f1 = f1;
    e.f2 = f2;
`ifdef HAZARD_PERF_EN
    e.sc = 32'(acc_sc);
`else
    e.sc = 32'd0;
`endif
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (rst)
      acc_sc = 0;
    else if (st && !flush)
      acc_sc++;
  endtask

  // Move past the next rising edge, then return all inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_issue = 1'b0; id_we = 1'b0; id_rd = 5'd0; id_lat = 3'd0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [2:0] lat);
    id_issue = 1'b1; id_we = 1'b1; id_rd = rd; id_lat = lat;
  endtask

  initial begin
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    expect_out("reset", 1'b0, 2'b00, 2'b00);

    // Four stall cycles, then a reset while still stalled.
    tick(); do_issue(5'd12, 3'd7); expect_out("perf.iss", 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick(); id_rs1 = 5'd12; id_use1 = 1'b1;
      expect_out($sformatf("perf.st%0d", k), 1'b1, 2'b00, 2'b00);
    end
    tick(); id_rs1 = 5'd12; id_use1 = 1'b1; rst = 1'b1;
    expect_out("perf.rst", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd12; id_use1 = 1'b1;
    expect_out("perf.after_rst", 1'b0, 2'b00, 2'b00);

    // The dependent stalls exactly id_lat cycles, then forwards from EX.
    tick(); do_issue(5'd5, 3'd2); expect_out("lat2.iss", 1'b0, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd5; id_use1 = 1'b1; expect_out("lat2.s1", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd5; id_use1 = 1'b1; expect_out("lat2.s2", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd5; id_use1 = 1'b1; id_issue = 1'b1;
    expect_out("lat2.go", 1'b0, 2'b00, 2'b00);
    tick(); ex_rs1 = 5'd5; ex_we = 1'b1; ex_rd = 5'd5;
    expect_out("lat2.fwd", 1'b0, 2'b01, 2'b00);

    // Latency 0: no stall at all.
    tick(); do_issue(5'd7, 3'd0); expect_out("lat0.iss", 1'b0, 2'b00, 2'b00);
    tick(); id_rs2 = 5'd7; id_use2 = 1'b1; expect_out("lat0.use", 1'b0, 2'b00, 2'b00);

    // x0 is never tracked and never forwarded.
    tick(); do_issue(5'd0, 3'd7); expect_out("x0.iss", 1'b0, 2'b00, 2'b00);
    tick(); id_use1 = 1'b1; id_use2 = 1'b1; ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
    expect_out("x0.use", 1'b0, 2'b00, 2'b00);

    // Forwarding priority.
    tick(); ex_rs2 = 5'd9; ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
    ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
    expect_out("fwd.ex", 1'b0, 2'b00, 2'b01);
    tick(); ex_rs2 = 5'd9; mem_we = 1'b1; wb_we = 1'b1;
    ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
    expect_out("fwd.mem", 1'b0, 2'b00, 2'b10);
    tick(); ex_rs2 = 5'd9; wb_we = 1'b1; ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
    expect_out("fwd.wb", 1'b0, 2'b00, 2'b11);
    tick(); ex_rs2 = 5'd9; ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
    expect_out("fwd.none", 1'b0, 2'b00, 2'b00);
    tick(); ex_rs1 = 5'd9; ex_rs2 = 5'd8; ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
    ex_rd = 5'd8; mem_rd = 5'd9; wb_rd = 5'd9;
    expect_out("fwd.mix", 1'b0, 2'b10, 2'b01);

    // A flush ends a long stall; a flush also beats a simultaneous issue.
    tick(); do_issue(5'd3, 3'd7); expect_out("fl.iss", 1'b0, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd3; id_use1 = 1'b1; expect_out("fl.s1", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd3; id_use1 = 1'b1; flush = 1'b1;
    expect_out("fl.flush", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd3; id_use1 = 1'b1; expect_out("fl.clear", 1'b0, 2'b00, 2'b00);
    tick(); do_issue(5'd4, 3'd3); flush = 1'b1; expect_out("fl.iss4", 1'b0, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd4; id_use1 = 1'b1; expect_out("fl.r4", 1'b0, 2'b00, 2'b00);

    // An issue while stalled is ignored.
    tick(); do_issue(5'd10, 3'd3); expect_out("ign.iss", 1'b0, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd10; id_use1 = 1'b1; do_issue(5'd11, 3'd5);
    expect_out("ign.s1", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd10; id_use1 = 1'b1; expect_out("ign.s2", 1'b1, 2'b00, 2'b00);
    tick(); id_rs1 = 5'd10; id_use1 = 1'b1; expect_out("ign.s3", 1'b1, 2'b00, 2'b00);
    tick(); id_rs2 = 5'd11; id_use2 = 1'b1; expect_out("ign.r11", 1'b0, 2'b00, 2'b00);

    // A re-issue wins over the decrement of the same register.
    tick(); do_issue(5'd6, 3'd2); expect_out("re.iss", 1'b0, 2'b00, 2'b00);
    tick(); expect_out("re.wait", 1'b0, 2'b00, 2'b00);
    tick(); do_issue(5'd6, 3'd3); expect_out("re.iss2", 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick(); id_rs2 = 5'd6; id_use2 = 1'b1;
      expect_out($sformatf("re.s%0d", k), 1'b1, 2'b00, 2'b00);
    end
    tick(); id_rs2 = 5'd6; id_use2 = 1'b1; expect_out("re.done", 1'b0, 2'b00, 2'b00);

    tick();
    tick();
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREGS, 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter AW, 5, register address width; SHALL satisfy 2^AW == NREGS.
REQ-003 Parameter CW, 3, latency counter width; issue latencies range 0..2^CW-1.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port id_rs1, id_rs2  input  AW each  decode-stage source addresses.
REQ-007 Port id_use1, id_use2  input  1 each  decode instruction actually reads rs1/rs2.
REQ-008 Port id_issue  input  1  decode instruction leaves decode this cycle (pipeline-qualified).
REQ-009 Port id_rd  input  AW  destination of the issuing instruction.
REQ-010 Port id_we  input  1  issuing instruction writes id_rd.
REQ-011 Port id_lat  input  CW  cycles until the issuing result becomes forwardable (0 = forwardable from EX next cycle).
REQ-012 Port ex_rs1, ex_rs2  input  AW each  EX-stage source addresses.
REQ-013 Port ex_we, mem_we, wb_we  input  1 each  stage holds a valid register write.
REQ-014 Port ex_rd, mem_rd, wb_rd  input  AW each  stage destination addresses.
REQ-015 Port flush  input  1  squash all in-flight younger instructions.
REQ-016 Port stall  output  1  hold decode and insert bubble into EX.
REQ-017 Port fwd1_sel, fwd2_sel  output  2 each  EX operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-018 Port stall_cycles  output  32  stall statistics counter (see Configuration).

Function
REQ-019 Block SHALL hold one CW-bit pending counter per register 1..NREGS-1; register 0 SHALL never be tracked and its counter SHALL read 0.
REQ-020 On a cycle with id_issue=1, id_we=1, id_rd!=0, stall=0, counter[id_rd] SHALL load id_lat at the next edge.
REQ-021 Every other nonzero counter SHALL decrement by 1 per cycle; zero counters SHALL remain 0 (no wrap).
REQ-022 Issue and decrement targeting the same register in one cycle: issue load SHALL win.
REQ-023 id_issue SHALL be ignored (no counter load) in any cycle where stall=1.
REQ-024 stall SHALL be combinational: 1 iff (id_use1 and counter[id_rs1]!=0) or (id_use2 and counter[id_rs2]!=0).
REQ-025 flush=1 SHALL clear all counters at the next edge; flush SHALL take priority over a simultaneous issue.
REQ-026 fwdN_sel SHALL be combinational with priority EX > MEM > WB: 01 if ex_we and ex_rd!=0 and ex_rsN==ex_rd, else 10 on MEM match, else 11 on WB match, else 00.
REQ-027 A source address of 0 SHALL always yield fwdN_sel=00.
REQ-028 Stall latency: a dependent instruction SHALL stall exactly id_lat cycles after the producer issues when it immediately follows in decode.

Reset
REQ-029 rst=1 at a rising edge SHALL clear all counters and stall_cycles; stall SHALL read 0 in the cycle after reset provided no inputs assert a dependency.
REQ-030 Reset asserted mid-stall SHALL terminate the stall at the next edge; reset SHALL have priority over flush and issue.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined: stall_cycles SHALL increment by 1 each cycle stall=1 and flush=0, saturating at 0xFFFFFFFF.
REQ-032 Macro HAZARD_PERF_EN undefined: stall_cycles SHALL be tied to 0 and no counter flops SHALL be instantiated.

Verification
REQ-033 Issue rd=5 lat=2, next cycle decode rs1=5 use1=1 -> stall=1 for 2 cycles, then 0; fwd1_sel=01 once dependent enters EX with ex_rd=5.
REQ-034 Issue rd=0 lat=7, then decode reads x0 -> stall never asserts, fwd sel stays 00.
REQ-035 ex_rd=mem_rd=wb_rd=9 all writing, ex_rs2=9 -> fwd2_sel=01; drop ex_we -> 10; drop mem_we -> 11.
REQ-036 Issue rd=3 lat=7, flush after 2 cycles with decode rs1=3 -> stall deasserts in the cycle after flush; simultaneous flush+issue rd=4 lat=3 -> counter[4]=0.
REQ-037 With HAZARD_PERF_EN: 4 stall cycles -> stall_cycles=4; rst mid-stall -> stall_cycles=0 and stall=0 next cycle; without macro -> stall_cycles constant 0.
REQ-038 Counter[6]=1 decrementing while new issue rd=6 lat=3 -> counter[6]=3 next cycle, dependent stalls 3 further cycles.
